spi_arbiter: RTL and testbench

Shares one `SPIMaster` between `NUM_REQ` on-chip requesters, such as the AHB bridge and accelerator DMA.
- Each requester hands over one transaction: up to 4 write bytes with a byte count.
- The block grants the master round-robin, sequences its enable/ready handshake and returns read data to the owning requester.
- Malformed requests and hung transfers are completed with an error flag and never wedge the bus.

---
 rtl/spi_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/spi_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_spi_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
//   - state_e       : transaction FSM states
//   - SPI_*         : word / byte-count widths of the SPIMaster interface
//   - bytes_ok()    : checks that a requested write byte count is 1..SPI_MAX_BYTES
package spi_arb_pkg;

  localparam int SPI_WORD_W    = 32;
  localparam int SPI_BYTES_W   = 3;
  localparam int SPI_MAX_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // A byte count of zero or above the master's capacity is a malformed request.
  function automatic logic bytes_ok(input logic [SPI_BYTES_W-1:0] bytes);
    return (bytes != 3'd0) && (bytes <= 3'(SPI_MAX_BYTES));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i  : request vector, one bit per requester
//   ptr_i  : index where the priority scan starts
//   gnt_o  : one-hot grant (all zero when no request)
//   idx_o  : binary index of the granted requester
//   any_o  : at least one request is pending
// The pointer register lives in the parent so it only advances on accept.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum_s;
  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Scan requesters starting at ptr_i, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s          = {1'b0, ptr_i} + SUM_W'(i);
      sum_s          = (sum_s >= SUM_W'(NUM_REQ)) ? (sum_s - SUM_W'(NUM_REQ)) : sum_s;
      cand_s         = sum_s[IDX_W-1:0];
      hit_s          = req_i[cand_s] & ~any_o;
      gnt_o[cand_s]  = gnt_o[cand_s] | hit_s;
      idx_o          = hit_s ? cand_s : idx_o;
      any_o          = any_o | hit_s;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPIMaster between NUM_REQ requesters.
// Each requester hands over one transaction (up to 4 write bytes); the winner
// is chosen round-robin, the master's enable/ready handshake is sequenced and
// the read data is returned to the owner. Malformed byte counts and transfers
// exceeding TIMEOUT_CYCLES complete with rsp_err_o set.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_valid_i/data/bytes  : per-requester transaction request
//   req_ready_o             : one-hot accept pulse (IDLE only)
//   rsp_valid_o             : one-hot completion pulse to the owner
//   rsp_data_o/bytes/err    : response payload, data held until next completion
//   ss_sel_o                : owner index while a transaction is in flight
//   m_enable_o/write/bytes  : drive to SPIMaster
//   m_ready_i/read data     : status and read data from SPIMaster
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [SPI_WORD_W*NUM_REQ-1:0]   req_data_i,
  input  logic [SPI_BYTES_W*NUM_REQ-1:0]  req_bytes_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [SPI_WORD_W-1:0]           rsp_data_o,
  output logic [SPI_BYTES_W-1:0]          rsp_bytes_o,
  output logic                            rsp_err_o,
  output logic [$clog2(NUM_REQ)-1:0]      ss_sel_o,
  output logic                            m_enable_o,
  output logic [SPI_WORD_W-1:0]           m_write_data_o,
  output logic [SPI_BYTES_W-1:0]          m_bytes_o,
  input  logic                            m_ready_i,
  input  logic [SPI_WORD_W-1:0]           m_read_data_i,
  input  logic [SPI_BYTES_W-1:0]          m_read_bytes_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SPI_WORD_W-1:0]  wdata_q, wdata_d;
  logic [SPI_BYTES_W-1:0] wbytes_q, wbytes_d;
  logic [SPI_WORD_W-1:0]  rsp_data_q, rsp_data_d;
  logic [SPI_BYTES_W-1:0] rsp_bytes_q, rsp_bytes_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]     arb_gnt_s;
  logic [IDX_W-1:0]       arb_idx_s;
  logic                   arb_any_s;
  logic [SPI_WORD_W-1:0]  sel_data_s;
  logic [SPI_BYTES_W-1:0] sel_bytes_s;
  logic [IDX_W-1:0]       ptr_next_s;
  logic                   timeout_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  // Select the winning requester's word and byte count.
  always_comb begin
    sel_data_s  = '0;
    sel_bytes_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data_s  = (arb_idx_s == IDX_W'(i)) ? req_data_i[i*SPI_WORD_W +: SPI_WORD_W] : sel_data_s;
      sel_bytes_s = (arb_idx_s == IDX_W'(i)) ? req_bytes_i[i*SPI_BYTES_W +: SPI_BYTES_W] : sel_bytes_s;
    end
  end

  assign ptr_next_s = (arb_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : (arb_idx_s + IDX_W'(1));
  assign timeout_s  = (cnt_q == CNT_LAST);

  // Next-state logic for the transaction FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    wbytes_d    = wbytes_q;
    rsp_data_d  = rsp_data_q;
    rsp_bytes_d = rsp_bytes_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          ptr_d   = ptr_next_s;
          owner_d = arb_idx_s;
          cnt_d   = '0;
          if (bytes_ok(sel_bytes_s)) begin
            state_d  = ST_LAUNCH;
            wdata_d  = sel_data_s;
            wbytes_d = sel_bytes_s;
          end else begin
            // Malformed: answer immediately, master never enabled.
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_bytes_d = '0;
            rsp_data_d  = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_s) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_bytes_d = '0;
        end else if (!m_ready_i) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion is checked first so it wins over a coincident expiry.
        if (m_ready_i) begin
          state_d     = ST_RESP;
          rsp_data_d  = m_read_data_i;
          rsp_bytes_d = m_read_bytes_i;
          rsp_err_d   = 1'b0;
        end else if (timeout_s) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_bytes_d = '0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      wbytes_q    <= '0;
      rsp_data_q  <= '0;
      rsp_bytes_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      wbytes_q    <= wbytes_d;
      rsp_data_q  <= rsp_data_d;
      rsp_bytes_q <= rsp_bytes_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Accept is masked during reset so every output reads zero while rst_i is high.
  assign req_ready_o    = ((state_q == ST_IDLE) && !rst_i) ? arb_gnt_s : '0;
  assign rsp_valid_o    = (state_q == ST_RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_bytes_o    = rsp_bytes_q;
  assign rsp_err_o      = rsp_err_q;
  assign ss_sel_o       = (state_q == ST_IDLE) ? '0 : owner_q;
  assign m_enable_o     = (state_q == ST_LAUNCH);
  assign m_write_data_o = (state_q == ST_LAUNCH) ? wdata_q : '0;
  assign m_bytes_o      = (state_q == ST_LAUNCH) ? wbytes_q : '0;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed testbench for spi_arbiter. Two instances share request data and
// master read data: dut_a (default timeout) covers arbitration, malformed
// requests and mid-transfer reset; dut_t (TIMEOUT_CYCLES=16) covers timeout
// and the completion/expiry collision.
module tb_spi_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid_a, req_valid_t;
  logic [127:0] req_data;
  logic [11:0]  req_bytes;
  logic         m_ready_a, m_ready_t;
  logic [31:0]  m_read_data;
  logic [2:0]   m_read_bytes;

  logic [3:0]  req_ready_a, rsp_valid_a, req_ready_t, rsp_valid_t;
  logic [31:0] rsp_data_a, rsp_data_t, m_wdata_a, m_wdata_t;
  logic [2:0]  rsp_bytes_a, rsp_bytes_t, m_bytes_a, m_bytes_t;
  logic        rsp_err_a, rsp_err_t, m_enable_a, m_enable_t;
  logic [1:0]  ss_sel_a, ss_sel_t;

  int n_asserts = 0;
  int n_fail    = 0;
  int rdy_cnt[4];
  logic overlap_seen;
  int cyc;

  spi_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(4096)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_a), .req_data_i(req_data), .req_bytes_i(req_bytes),
    .req_ready_o(req_ready_a), .rsp_valid_o(rsp_valid_a), .rsp_data_o(rsp_data_a),
    .rsp_bytes_o(rsp_bytes_a), .rsp_err_o(rsp_err_a), .ss_sel_o(ss_sel_a),
    .m_enable_o(m_enable_a), .m_write_data_o(m_wdata_a), .m_bytes_o(m_bytes_a),
    .m_ready_i(m_ready_a), .m_read_data_i(m_read_data), .m_read_bytes_i(m_read_bytes)
  );

  spi_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut_t (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_t), .req_data_i(req_data), .req_bytes_i(req_bytes),
    .req_ready_o(req_ready_t), .rsp_valid_o(rsp_valid_t), .rsp_data_o(rsp_data_t),
    .rsp_bytes_o(rsp_bytes_t), .rsp_err_o(rsp_err_t), .ss_sel_o(ss_sel_t),
    .m_enable_o(m_enable_t), .m_write_data_o(m_wdata_t), .m_bytes_o(m_bytes_t),
    .m_ready_i(m_ready_t), .m_read_data_i(m_read_data), .m_read_bytes_i(m_read_bytes)
  );

  always #5 clk = ~clk;

  // Count accept pulses per requester and flag any ready/response overlap.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rdy_cnt[i] <= 0;
      overlap_seen <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) if (req_ready_a[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
      if (((|req_ready_a) && (|rsp_valid_a)) || ((|req_ready_t) && (|rsp_valid_t)))
        overlap_seen <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // One well-formed transaction on dut_a, starting in an IDLE cycle.
  task automatic serve(input int w, input logic [31:0] rd);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    m_ready_a    = 1'b1;
    m_read_data  = rd;
    m_read_bytes = 3'd4;
    #1;
    chk("grant", {28'd0, req_ready_a}, {28'd0, oh});
    nxt();
    chk("launch_en", {31'd0, m_enable_a}, 32'd1);
    chk("launch_wdata", m_wdata_a, req_data[32*w +: 32]);
    chk("launch_bytes", {29'd0, m_bytes_a}, {29'd0, req_bytes[3*w +: 3]});
    chk("launch_sel", {30'd0, ss_sel_a}, 32'(w));
    chk("launch_noready", {28'd0, req_ready_a}, 32'd0);
    m_ready_a = 1'b0;
    nxt();
    chk("busy_en", {31'd0, m_enable_a}, 32'd0);
    m_ready_a = 1'b1;
    nxt();
    chk("rsp_valid", {28'd0, rsp_valid_a}, {28'd0, oh});
    chk("rsp_data", rsp_data_a, rd);
    chk("rsp_err", {31'd0, rsp_err_a}, 32'd0);
    nxt();
  endtask

  // One transaction on dut_t; m_ready_t rises from cycle rise_at on.
  // Returns the cycle (relative to accept) where rsp_valid_t is seen, or -1.
  task automatic run_t(input logic [3:0] v, input int rise_at, output int rsp_cyc);
    rsp_cyc     = -1;
    req_valid_t = v;
    m_ready_t   = 1'b1;
    #1;
    chk("t_accept", {28'd0, req_ready_t}, {28'd0, v});
    for (int c = 1; c <= 40 && rsp_cyc < 0; c++) begin
      nxt();
      req_valid_t = 4'd0;
      m_ready_t   = (c >= rise_at) ? 1'b1 : 1'b0;
      #1;
      if (c == 1) chk("t_launch_en", {31'd0, m_enable_t}, 32'd1);
      if (rsp_valid_t != 4'd0) rsp_cyc = c;
    end
  endtask

  initial begin
    req_valid_a  = 4'b1111;
    req_valid_t  = 4'b0000;
    m_ready_a    = 1'b1;
    m_ready_t    = 1'b1;
    m_read_data  = 32'd0;
    m_read_bytes = 3'd0;
    req_data     = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h695A_0FC3};
    req_bytes    = {3'd3, 3'd1, 3'd4, 3'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", {28'd0, req_ready_a}, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid_a}, 32'd0);
    chk("rst_enable", {31'd0, m_enable_a}, 32'd0);
    chk("rst_sel", {30'd0, ss_sel_a}, 32'd0);
    chk("rst_rsp_data", rsp_data_a, 32'd0);
    chk("rst_wdata", m_wdata_a, 32'd0);
    chk("rst_err_t", {31'd0, rsp_err_t}, 32'd0);
    rst = 1'b0;

    // Fairness: all valid continuously -> 0,1,2,3,0
    for (int k = 0; k < 5; k++) serve(k % 4, 32'hA000_0000 | 32'(k));
    req_valid_a = 4'd0;
    chk("fair_cnt0", 32'(rdy_cnt[0]), 32'd2);
    chk("fair_cnt1", 32'(rdy_cnt[1]), 32'd1);
    chk("fair_cnt2", 32'(rdy_cnt[2]), 32'd1);
    chk("fair_cnt3", 32'(rdy_cnt[3]), 32'd1);

    // Single request from requester 0 (pointer sits at 1, so the scan wraps)
    req_valid_a = 4'b0001;
    m_ready_a   = 1'b1;
    #1;
    chk("single_grant", {28'd0, req_ready_a}, 32'h1);
    nxt();
    req_valid_a = 4'd0;
    chk("single_en", {31'd0, m_enable_a}, 32'd1);
    chk("single_wdata", m_wdata_a, 32'h695A_0FC3);
    chk("single_bytes", {29'd0, m_bytes_a}, 32'd2);
    m_ready_a = 1'b0;
    nxt();
    chk("single_busy_en", {31'd0, m_enable_a}, 32'd0);
    repeat (38) nxt();
    chk("single_not_done", {28'd0, rsp_valid_a}, 32'd0);
    m_ready_a    = 1'b1;
    m_read_data  = 32'hDEAD_BEEF;
    m_read_bytes = 3'd2;
    nxt();
    chk("single_rsp_valid", {28'd0, rsp_valid_a}, 32'h1);
    chk("single_rsp_data", rsp_data_a, 32'hDEAD_BEEF);
    chk("single_rsp_bytes", {29'd0, rsp_bytes_a}, 32'd2);
    chk("single_rsp_err", {31'd0, rsp_err_a}, 32'd0);
    nxt();
    chk("single_idle_valid", {28'd0, rsp_valid_a}, 32'd0);
    chk("single_hold_data", rsp_data_a, 32'hDEAD_BEEF);
    chk("single_idle_sel", {30'd0, ss_sel_a}, 32'd0);

    // Malformed requests from requester 2: bytes 0, then bytes 5
    for (int m = 0; m < 2; m++) begin
      req_bytes[8:6] = (m == 0) ? 3'd0 : 3'd5;
      req_valid_a    = 4'b0100;
      #1;
      chk("mal_grant", {28'd0, req_ready_a}, 32'h4);
      nxt();
      req_valid_a = 4'd0;
      chk("mal_rsp_valid", {28'd0, rsp_valid_a}, 32'h4);
      chk("mal_err", {31'd0, rsp_err_a}, 32'd1);
      chk("mal_bytes", {29'd0, rsp_bytes_a}, 32'd0);
      chk("mal_data", rsp_data_a, 32'd0);
      chk("mal_en", {31'd0, m_enable_a}, 32'd0);
      chk("mal_sel", {30'd0, ss_sel_a}, 32'd2);
      nxt();
      chk("mal_idle_en", {31'd0, m_enable_a}, 32'd0);
      chk("mal_idle_valid", {28'd0, rsp_valid_a}, 32'd0);
    end
    req_bytes[8:6] = 3'd1;

    // Mid-transfer reset: pointer is 3, so requester 3 wins over 1
    req_valid_a = 4'b1010;
    m_ready_a   = 1'b1;
    #1;
    chk("mrst_grant", {28'd0, req_ready_a}, 32'h8);
    nxt();
    req_valid_a = 4'b0010;
    chk("mrst_launch_sel", {30'd0, ss_sel_a}, 32'd3);
    m_ready_a = 1'b0;
    nxt();
    chk("mrst_busy_sel", {30'd0, ss_sel_a}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mrst_sel0", {30'd0, ss_sel_a}, 32'd0);
    chk("mrst_en0", {31'd0, m_enable_a}, 32'd0);
    chk("mrst_ready0", {28'd0, req_ready_a}, 32'd0);
    m_ready_a   = 1'b1;
    req_valid_a = 4'b1011;
    nxt();
    chk("mrst_no_rsp", {28'd0, rsp_valid_a}, 32'd0);
    chk("mrst_ready_held", {28'd0, req_ready_a}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_after_no_rsp", {28'd0, rsp_valid_a}, 32'd0);
    serve(0, 32'h5555_AAAA);
    req_valid_a = 4'd0;

    // Collision: m_ready_t rises on the edge where the counter expires
    m_read_data  = 32'h0A0B_0C0D;
    m_read_bytes = 3'd3;
    run_t(4'b0001, 16, cyc);
    chk("coll_cycle", 32'(cyc), 32'd17);
    chk("coll_valid", {28'd0, rsp_valid_t}, 32'h1);
    chk("coll_err", {31'd0, rsp_err_t}, 32'd0);
    chk("coll_data", rsp_data_t, 32'h0A0B_0C0D);
    chk("coll_bytes", {29'd0, rsp_bytes_t}, 32'd3);
    nxt();

    // Timeout: master never returns ready
    m_read_data = 32'hFFFF_FFFF;
    run_t(4'b0001, 100, cyc);
    chk("to_cycle", 32'(cyc), 32'd17);
    chk("to_valid", {28'd0, rsp_valid_t}, 32'h1);
    chk("to_err", {31'd0, rsp_err_t}, 32'd1);
    chk("to_bytes", {29'd0, rsp_bytes_t}, 32'd0);
    chk("to_data_kept", rsp_data_t, 32'h0A0B_0C0D);
    chk("to_en", {31'd0, m_enable_t}, 32'd0);
    nxt();

    // Next request after timeout is served normally
    m_read_data = 32'h1234_5678;
    run_t(4'b0001, 5, cyc);
    chk("post_to_cycle", 32'(cyc), 32'd6);
    chk("post_to_err", {31'd0, rsp_err_t}, 32'd0);
    chk("post_to_data", rsp_data_t, 32'h1234_5678);
    chk("post_to_bytes", {29'd0, rsp_bytes_t}, 32'd3);
    nxt();

    chk("no_ready_rsp_overlap", {31'd0, overlap_seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
